bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  Time-of-day source for the clock display. Produces six 4-bit BCD digits
//  (HH:MM:SS) that feed the per-digit 7-segment decoders.
//  Contains a 1 Hz prescaler from CLK, a cascaded seconds/minutes/hours BCD
//  chain, and minute/hour set inputs. Digit values never leave 0..9.
// PARAMETERS
//  TICK_DIV  50000000  CLK cycles per 1 s tick; legal range >= 2
// PORTS
//  CLK       in   1  system clock; all state updates on rising edge
//  RESET     in   1  asynchronous, active-high reset
//  EN        in   1  1 = time runs; 0 = prescaler and time frozen
//  INC_MIN   in   1  1-cycle pulse, synchronous and debounced upstream: minutes +1
//  INC_HOUR  in   1  1-cycle pulse, synchronous and debounced upstream: hours +1
//  SEC_L     out  4  seconds units, BCD 0..9
//  SEC_H     out  4  seconds tens, BCD 0..5
//  MIN_L     out  4  minutes units, BCD 0..9
//  MIN_H     out  4  minutes tens, BCD 0..5
//  HOUR_L    out  4  hours units, BCD
//  HOUR_H    out  4  hours tens, BCD 0..2
//  PM        out  1  PM flag (12 h build only, else constant 0)
//  TICK      out  1  1-cycle pulse on each 1 s advance
// BEHAVIOUR
//  - All outputs are registered. RESET forces prescaler=0, TICK=0, PM=0, all digits 0,
//    giving 00:00:00. In the 12 h build it gives 12:00:00 AM.
//  - Prescaler: ceil(log2(TICK_DIV)) bits. Counts 0..TICK_DIV-1 while EN=1 and wraps to 0.
//    Internal tick = EN && prescaler==TICK_DIV-1. TICK output = that tick delayed 1 cycle,
//    aligned with the digit update.
//  - Latency: digits change on the edge after the internal tick, visible with TICK=1.
//  - EN=0: prescaler holds its value, no ticks, digits hold. INC_MIN and INC_HOUR are still honoured.
//  - Carry chain on a tick:
//    - SEC_L 9->0 carries to SEC_H.
//    - SEC_H:SEC_L 59->00 carries to minutes.
//    - Minutes 59->00 carries to hours.
//    - 24 h mode: hours 23->00, no further carry.
//  - Next hour = hour + minute_carry + INC_HOUR, modulo wrap. A carry and an INC_HOUR in the
//    same cycle advance the hour by 2 (e.g. 22:59:59 + both -> 00:00:00).
//  - INC_MIN has priority over the tick in the same cycle:
//    - Seconds cleared to 00 and prescaler cleared to 0.
//    - Minutes +1, wrapping 59->00 with NO carry into hours.
//    - The tick is discarded and TICK stays 0 that cycle.
//  - INC_MIN and INC_HOUR together: both apply independently; the minute wrap never feeds hours.
//  - INC_HOUR alone changes hours only. Seconds and prescaler are untouched.
//  - Arithmetic is digit-wise BCD only. No binary intermediate counters for time.
//  - RESET asserted mid-second: immediate return to the reset state. The first tick comes
//    TICK_DIV cycles after RESET deasserts with EN=1.
// CONFIGURATION
//  HOUR12_EN (macro, `ifdef):
//  - Defined: hours run 12,01,02..11,12. PM toggles whenever hours step 11->12, whether by
//    carry or by INC_HOUR. Reset = 12 AM. Hours never show 00 or >12.
//  - Undefined: 24 h mode, hours 00..23, PM tied to 0.
// TESTING (bench uses TICK_DIV=4)
//  1. RESET pulse mid-count, EN=1 for 4 cycles -> 00:00:00, then TICK 1 cycle, SEC_L=1.
//     Subsequent TICKs every 4 cycles.
//  2. Preset 00:00:59 via INC_MIN x0 plus 59 ticks; next tick -> 00:01:00.
//     At 23:59:59 the next tick -> 00:00:00 with all digits 0.
//  3. EN=0 for 20 cycles at prescaler=2 -> no TICK, digits hold.
//     EN=1 -> TICK after exactly 2 cycles.
//  4. INC_MIN in the same cycle as the tick at 00:59:58 -> 00:00:00 minute 00, hours unchanged,
//     TICK=0. The next TICK follows 4 cycles later.
//  5. At 22:59:59 pulse INC_HOUR on the tick cycle -> 00:00:00.
//     At 09:xx, INC_HOUR -> HOUR_H=1, HOUR_L=0.
//  6. HOUR12_EN build: reset -> 12:00:00, PM=0.
//     11:59:59 + tick -> 12:00:00, PM=1. Then 12:59:59 + tick -> 01:00:00, PM=1.

Source files
------------

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - HH:MM:SS BCD time-of-day counter with 1 s prescaler and minute/hour set inputs.
// Define HOUR12_EN for the 12 h build (hours 12,01..11 with PM flag); default is 24 h.
module bcd_time_counter #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       EN,
   input  logic       INC_MIN,
   input  logic       INC_HOUR,
   output logic [3:0] SEC_L,
   output logic [3:0] SEC_H,
   output logic [3:0] MIN_L,
   output logic [3:0] MIN_H,
   output logic [3:0] HOUR_L,
   output logic [3:0] HOUR_H,
   output logic       PM,
   output logic       TICK
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

`ifdef HOUR12_EN
   localparam logic [3:0] HOUR_H_RST = 4'd1;
   localparam logic [3:0] HOUR_L_RST = 4'd2;
`else
   localparam logic [3:0] HOUR_H_RST = 4'd0;
   localparam logic [3:0] HOUR_L_RST = 4'd0;
`endif

   logic [PW-1:0] pre;
   logic          tick_int;
   logic          adv;
   logic          sec_carry;
   logic          min_carry;
   logic [PW-1:0] pre_next;
   logic [7:0]    sec_next;
   logic [7:0]    min_next;
   logic [3:0]    h1_h, h1_l, h2_h, h2_l;
   logic          t1, t2;

   // Two-digit 00..59 BCD increment, returned as {tens, units}.
   function automatic logic [7:0] inc59(input logic [3:0] h, input logic [3:0] l);
      logic [7:0] r;
      if (l == 4'd9) begin
         r = {((h == 4'd5) ? 4'd0 : h + 4'd1), 4'd0};
      end else begin
         r = {h, l + 4'd1};
      end
      return r;
   endfunction

   // One hour step, returned as {tens, units, pm_toggle}.
   function automatic logic [8:0] inc_hour(input logic [3:0] h, input logic [3:0] l);
      logic [8:0] r;
`ifdef HOUR12_EN
      if (h == 4'd1 && l == 4'd2) begin
         r = {4'd0, 4'd1, 1'b0};
      end else if (l == 4'd9) begin
         r = {h + 4'd1, 4'd0, 1'b0};
      end else begin
         r = {h, l + 4'd1, (h == 4'd1 && l == 4'd1)};
      end
`else
      if (h == 4'd2 && l == 4'd3) begin
         r = {4'd0, 4'd0, 1'b0};
      end else if (l == 4'd9) begin
         r = {h + 4'd1, 4'd0, 1'b0};
      end else begin
         r = {h, l + 4'd1, 1'b0};
      end
`endif
      return r;
   endfunction

   assign tick_int  = EN && (pre == PRE_MAX);
   // INC_MIN swallows a coincident tick entirely.
   assign adv       = tick_int && !INC_MIN;
   assign sec_carry = adv && (SEC_H == 4'd5) && (SEC_L == 4'd9);
   assign min_carry = sec_carry && (MIN_H == 4'd5) && (MIN_L == 4'd9);

   always_comb begin
      pre_next = pre;
      if (INC_MIN) begin
         pre_next = '0;
      end else if (EN) begin
         pre_next = (pre == PRE_MAX) ? '0 : pre + PW'(1);
      end
   end

   always_comb begin
      sec_next = {SEC_H, SEC_L};
      if (INC_MIN) begin
         sec_next = 8'h00;
      end else if (adv) begin
         sec_next = inc59(SEC_H, SEC_L);
      end
   end

   always_comb begin
      min_next = {MIN_H, MIN_L};
      if (INC_MIN || sec_carry) begin
         min_next = inc59(MIN_H, MIN_L);
      end
   end

   // Carry and INC_HOUR are applied as two chained single steps.
   always_comb begin
      {h1_h, h1_l, t1} = {HOUR_H, HOUR_L, 1'b0};
      if (min_carry) begin
         {h1_h, h1_l, t1} = inc_hour(HOUR_H, HOUR_L);
      end
      {h2_h, h2_l, t2} = {h1_h, h1_l, 1'b0};
      if (INC_HOUR) begin
         {h2_h, h2_l, t2} = inc_hour(h1_h, h1_l);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pre    <= '0;
         TICK   <= 1'b0;
         PM     <= 1'b0;
         SEC_L  <= 4'd0;
         SEC_H  <= 4'd0;
         MIN_L  <= 4'd0;
         MIN_H  <= 4'd0;
         HOUR_L <= HOUR_L_RST;
         HOUR_H <= HOUR_H_RST;
      end else begin
         pre            <= pre_next;
         TICK           <= adv;
         PM             <= PM ^ t1 ^ t2;
         {SEC_H, SEC_L} <= sec_next;
         {MIN_H, MIN_L} <= min_next;
         HOUR_H         <= h2_h;
         HOUR_L         <= h2_l;
      end
   end

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter (TICK_DIV=4).
// Runs 24 h checks by default; the HOUR12_EN build swaps in the 12 h checks.
module tb_bcd_time_counter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       EN = 1'b0;
   logic       INC_MIN = 1'b0;
   logic       INC_HOUR = 1'b0;
   logic [3:0] SEC_L, SEC_H, MIN_L, MIN_H, HOUR_L, HOUR_H;
   logic       PM, TICK;

   int total = 0;
   int bad = 0;

`ifdef HOUR12_EN
   localparam logic [7:0] HR0 = 8'h12;
`else
   localparam logic [7:0] HR0 = 8'h00;
`endif

   bcd_time_counter #(.TICK_DIV(4)) dut (
      .CLK(CLK), .RESET(RESET), .EN(EN), .INC_MIN(INC_MIN), .INC_HOUR(INC_HOUR),
      .SEC_L(SEC_L), .SEC_H(SEC_H), .MIN_L(MIN_L), .MIN_H(MIN_H),
      .HOUR_L(HOUR_L), .HOUR_H(HOUR_H), .PM(PM), .TICK(TICK)
   );

   always #5 CLK = ~CLK;

   function automatic logic [23:0] now();
      return {HOUR_H, HOUR_L, MIN_H, MIN_L, SEC_H, SEC_L};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse_min(input int n);
      for (int i = 0; i < n; i++) begin
         INC_MIN = 1'b1;
         step();
         INC_MIN = 1'b0;
      end
   endtask

   task automatic pulse_hour(input int n);
      for (int i = 0; i < n; i++) begin
         INC_HOUR = 1'b1;
         step();
         INC_HOUR = 1'b0;
      end
   endtask

   // Bounded wait for the next TICK; a timeout shows up as a failed check.
   task automatic wait_tick(input string tag);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (TICK !== 1'b1 && k < 10);
      if (TICK !== 1'b1) chk(tag, {31'd0, TICK}, 32'd1);
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick("tick_timeout");
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_time", {8'd0, now()}, {8'd0, HR0, 16'h0000});
      chk("rst_tick", {31'd0, TICK}, 32'd0);
      chk("rst_pm", {31'd0, PM}, 32'd0);
      RESET = 1'b0;
      EN = 1'b1;
      step();
      step();
      // Reset mid-count: first TICK exactly 4 cycles after release
      RESET = 1'b1;
      #1;
      chk("midrst_time", {8'd0, now()}, {8'd0, HR0, 16'h0000});
      step();
      RESET = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("first_wait_tick", {31'd0, TICK}, 32'd0);
      end
      step();
      chk("first_tick", {31'd0, TICK}, 32'd1);
      chk("first_sec", {8'd0, now()}, {8'd0, HR0, 16'h0001});
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("period_gap", {31'd0, TICK}, 32'd0);
      end
      step();
      chk("second_tick", {31'd0, TICK}, 32'd1);
      chk("second_sec", {8'd0, now()}, {8'd0, HR0, 16'h0002});

      // EN=0 freeze at prescaler=2
      step();
      step();
      EN = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (TICK !== 1'b0) chk("freeze_tick", {31'd0, TICK}, 32'd0);
      end
      chk("freeze_time", {8'd0, now()}, {8'd0, HR0, 16'h0002});
      EN = 1'b1;
      step();
      chk("resume_1", {31'd0, TICK}, 32'd0);
      step();
      chk("resume_2", {31'd0, TICK}, 32'd1);
      chk("resume_sec", {8'd0, now()}, {8'd0, HR0, 16'h0003});

      // Seconds 59 -> minute carry
      run_ticks(56);
      chk("sec59", {8'd0, now()}, {8'd0, HR0, 16'h0059});
      wait_tick("tick_timeout");
      chk("sec_carry", {8'd0, now()}, {8'd0, HR0, 16'h0100});

      // INC_MIN coincident with tick at xx:59:58
      EN = 1'b0;
      pulse_min(58);
      chk("incmin_preset", {8'd0, now()}, {8'd0, HR0, 16'h5900});
      EN = 1'b1;
      run_ticks(58);
      chk("at_5958", {8'd0, now()}, {8'd0, HR0, 16'h5958});
      step();
      step();
      step();
      INC_MIN = 1'b1;
      step();
      INC_MIN = 1'b0;
      chk("incmin_tick_time", {8'd0, now()}, {8'd0, HR0, 16'h0000});
      chk("incmin_tick_flag", {31'd0, TICK}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("incmin_gap", {31'd0, TICK}, 32'd0);
      end
      step();
      chk("incmin_next_tick", {31'd0, TICK}, 32'd1);
      chk("incmin_next_sec", {8'd0, now()}, {8'd0, HR0, 16'h0001});

`ifdef HOUR12_EN
      // 11:59:59 -> 12:00:00 PM, 12:59:59 -> 01:00:00 PM
      EN = 1'b0;
      pulse_hour(11);
      chk("h12_at11", {8'd0, now()}, 32'h00110001);
      chk("h12_pm_am", {31'd0, PM}, 32'd0);
      pulse_min(59);
      EN = 1'b1;
      run_ticks(59);
      chk("h12_115959", {8'd0, now()}, 32'h00115959);
      wait_tick("tick_timeout");
      chk("h12_noon", {8'd0, now()}, 32'h00120000);
      chk("h12_pm_set", {31'd0, PM}, 32'd1);
      EN = 1'b0;
      pulse_min(59);
      EN = 1'b1;
      run_ticks(59);
      chk("h12_125959", {8'd0, now()}, 32'h00125959);
      wait_tick("tick_timeout");
      chk("h12_one", {8'd0, now()}, 32'h00010000);
      chk("h12_pm_hold", {31'd0, PM}, 32'd1);
`else
      // 23:59:59 -> 00:00:00
      EN = 1'b0;
      pulse_hour(23);
      chk("inchour_only", {8'd0, now()}, 32'h00230001);
      pulse_min(59);
      EN = 1'b1;
      run_ticks(59);
      chk("at_235959", {8'd0, now()}, 32'h00235959);
      wait_tick("tick_timeout");
      chk("day_wrap", {8'd0, now()}, 32'h00000000);
      chk("pm_24h", {31'd0, PM}, 32'd0);

      // 22:59:59 + INC_HOUR on the tick cycle -> 00:00:00
      EN = 1'b0;
      pulse_hour(22);
      pulse_min(59);
      EN = 1'b1;
      run_ticks(59);
      chk("at_225959", {8'd0, now()}, 32'h00225959);
      step();
      step();
      step();
      INC_HOUR = 1'b1;
      step();
      INC_HOUR = 1'b0;
      chk("carry_plus_inc", {8'd0, now()}, 32'h00000000);
      chk("carry_plus_tick", {31'd0, TICK}, 32'd1);

      // 09 -> 10 via INC_HOUR
      EN = 1'b0;
      pulse_hour(9);
      chk("at_09", {8'd0, now()}, 32'h00090000);
      pulse_hour(1);
      chk("hour_09_10", {24'd0, HOUR_H, HOUR_L}, 32'h10);

      // INC_MIN + INC_HOUR together at minute 59: no minute carry into hours
      pulse_min(59);
      INC_MIN = 1'b1;
      INC_HOUR = 1'b1;
      step();
      INC_MIN = 1'b0;
      INC_HOUR = 1'b0;
      chk("both_inc", {8'd0, now()}, 32'h00110000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
